vga_fb_scanout: RTL

Parametrised successor to the fixed 640x480 framebuffer reader in the VGA path. Generates VGA timing from parameters and produces framebuffer read addresses, with integer pixel replication (SCALE). Absorbs a configurable memory read latency so sync, blanking and colour stay aligned. Sits between the pixel-clock domain of the dual-port BRAM (port B) and the VGA output pins.

---
 rtl/vga_pkg.sv | 75 +++++++
 rtl/vga_timing.sv | 64 ++++++
 rtl/vga_fb_scanout.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg                                                              |
// | Shared VGA timing defaults, pixel formats and colour-bar constants.  |
// | Rev 1.0 - initial parametrised scan-out package                      |
// +----------------------------------------------------------------------+
package vga_pkg;

    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;

    typedef enum logic [0:0] {
        FMT_RGB444 = 1'b0,
        FMT_RGB565 = 1'b1
    } pix_fmt_e;

    localparam logic [11:0] c_bar_white   = 12'hFFF;
    localparam logic [11:0] c_bar_yellow  = 12'hFF0;
    localparam logic [11:0] c_bar_cyan    = 12'h0FF;
    localparam logic [11:0] c_bar_green   = 12'h0F0;
    localparam logic [11:0] c_bar_magenta = 12'hF0F;
    localparam logic [11:0] c_bar_red     = 12'hF00;
    localparam logic [11:0] c_bar_blue    = 12'h00F;
    localparam logic [11:0] c_bar_black   = 12'h000;

    // Control bits that travel alongside the memory read
    typedef struct packed {
        logic vis;
        logic hsync;
        logic vsync;
        logic first;
    } ctl_t;

    function automatic int calc_h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int calc_v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        logic [11:0] col;
        case (idx)
            3'd0:    col = c_bar_white;
            3'd1:    col = c_bar_yellow;
            3'd2:    col = c_bar_cyan;
            3'd3:    col = c_bar_green;
            3'd4:    col = c_bar_magenta;
            3'd5:    col = c_bar_red;
            3'd6:    col = c_bar_blue;
            default: col = c_bar_black;
        endcase
        return col;
    endfunction

    // RGB565 keeps the top four bits of each channel
    function automatic logic [11:0] fmt_pixel(input logic [15:0] d, input pix_fmt_e fmt);
        logic [11:0] col;
        if (fmt == FMT_RGB565) begin
            col = {d[15:12], d[10:7], d[4:1]};
        end else begin
            col = d[11:0];
        end
        return col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing                                                           |
// | Horizontal/vertical counters, visible flag and raw sync windows.     |
// | Rev 1.0 - initial parametrised timing generator                      |
// +----------------------------------------------------------------------+
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp
) (
    input  logic clk,
    input  logic rst,
    output logic o_visible,
    output logic o_act_last,
    output logic o_frame_first,
    output logic o_frame_end,
    output logic o_hsync,
    output logic o_vsync
);

    localparam int c_h_total = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int c_hcnt_w  = $clog2(c_h_total);
    localparam int c_vcnt_w  = $clog2(c_v_total);

    logic [c_hcnt_w-1:0] r_hcnt;
    logic [c_vcnt_w-1:0] r_vcnt;
    logic                w_line_end;
    logic                w_last_line;

    assign w_line_end  = (r_hcnt == c_hcnt_w'(c_h_total - 1));
    assign w_last_line = (r_vcnt == c_vcnt_w'(c_v_total - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_line_end) begin
            r_hcnt <= '0;
            r_vcnt <= w_last_line ? '0 : r_vcnt + c_vcnt_w'(1);
        end else begin
            r_hcnt <= r_hcnt + c_hcnt_w'(1);
        end
    end

    assign o_visible     = (r_hcnt < c_hcnt_w'(H_ACTIVE)) && (r_vcnt < c_vcnt_w'(V_ACTIVE));
    assign o_act_last    = o_visible && (r_hcnt == c_hcnt_w'(H_ACTIVE - 1));
    assign o_frame_first = (r_hcnt == '0) && (r_vcnt == '0);
    assign o_frame_end   = w_line_end && w_last_line;
    assign o_hsync       = (r_hcnt >= c_hcnt_w'(H_ACTIVE + H_FP)) &&
                           (r_hcnt <  c_hcnt_w'(H_ACTIVE + H_FP + H_SYNC));
    assign o_vsync       = (r_vcnt >= c_vcnt_w'(V_ACTIVE + V_FP)) &&
                           (r_vcnt <  c_vcnt_w'(V_ACTIVE + V_FP + V_SYNC));

endmodule
`default_nettype wire

// File: rtl/vga_fb_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_fb_scanout                                                       |
// | Framebuffer scan-out: timing, scaled read addresses, latency-aligned |
// | sync/de/colour. Optional colour bars via VGA_TEST_PATTERN_EN.        |
// | Rev 1.0 - parametrised successor of the fixed 640x480 reader         |
// +----------------------------------------------------------------------+
module vga_fb_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp,
    parameter int SYNC_POL = 0,
    parameter int SCALE    = 1,
    parameter int PIX_FMT  = 0,
    parameter int MEM_LAT  = 1,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [15:0]       mem_data,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic [11:0]       rgb,
    output logic              frame_start,
    input  logic              test_mode
);

    localparam int c_fb_w  = H_ACTIVE / SCALE;
    localparam int c_fb_h  = V_ACTIVE / SCALE;
    localparam int c_sub_w = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [c_sub_w-1:0] c_sub_last  = c_sub_w'(SCALE - 1);
    localparam logic [ADDR_W-1:0]  c_line_step = ADDR_W'(c_fb_w);
    localparam pix_fmt_e           c_fmt       = (PIX_FMT == 1) ? FMT_RGB565 : FMT_RGB444;
    localparam logic               c_sync_on   = (SYNC_POL != 0);

    generate
        if ((64'(c_fb_w) * 64'(c_fb_h)) > (64'd1 << ADDR_W)) begin : g_addr_range_err
            $error("vga_fb_scanout: framebuffer does not fit ADDR_W");
        end
        if (SCALE != 1 && SCALE != 2 && SCALE != 4) begin : g_scale_err
            $error("vga_fb_scanout: SCALE must be 1, 2 or 4");
        end
        if (MEM_LAT < 1 || MEM_LAT > 3) begin : g_lat_err
            $error("vga_fb_scanout: MEM_LAT must be 1..3");
        end
    endgenerate

    logic w_visible;
    logic w_act_last;
    logic w_frame_first;
    logic w_frame_end;
    logic w_hsync;
    logic w_vsync;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .o_visible     (w_visible),
        .o_act_last    (w_act_last),
        .o_frame_first (w_frame_first),
        .o_frame_end   (w_frame_end),
        .o_hsync       (w_hsync),
        .o_vsync       (w_vsync)
    );

    // Address generator: replication handled by sub-pixel/sub-line counters
    logic [c_sub_w-1:0] r_xsub;
    logic [c_sub_w-1:0] r_ysub;
    logic [ADDR_W-1:0]  r_col;
    logic [ADDR_W-1:0]  r_line_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xsub      <= '0;
            r_ysub      <= '0;
            r_col       <= '0;
            r_line_base <= '0;
        end else begin
            if (w_act_last) begin
                r_xsub <= '0;
                r_col  <= '0;
                if (r_ysub == c_sub_last) begin
                    r_ysub      <= '0;
                    r_line_base <= r_line_base + c_line_step;
                end else begin
                    r_ysub <= r_ysub + c_sub_w'(1);
                end
            end else if (w_visible) begin
                if (r_xsub == c_sub_last) begin
                    r_xsub <= '0;
                    r_col  <= r_col + ADDR_W'(1);
                end else begin
                    r_xsub <= r_xsub + c_sub_w'(1);
                end
            end
            if (w_frame_end) begin
                r_line_base <= '0;
                r_ysub      <= '0;
            end
        end
    end

    logic        w_rd;
    logic        w_tp_sel;
    logic [11:0] w_tp_rgb;

`ifdef VGA_TEST_PATTERN_EN
    localparam int c_bar_w  = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int c_bsub_w = (c_bar_w > 1) ? $clog2(c_bar_w) : 1;

    logic [c_bsub_w-1:0] r_bar_sub;
    logic [2:0]          r_bar_idx;
    logic                r_tp     [0:MEM_LAT];
    logic [11:0]         r_tp_col [0:MEM_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bar_sub <= '0;
            r_bar_idx <= '0;
        end else if (w_act_last) begin
            r_bar_sub <= '0;
            r_bar_idx <= '0;
        end else if (w_visible) begin
            if (r_bar_sub == c_bsub_w'(c_bar_w - 1)) begin
                r_bar_sub <= '0;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_sub <= r_bar_sub + c_bsub_w'(1);
            end
        end
    end

    // Pattern colour rides a delay line matching the memory path
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= MEM_LAT; i++) begin
                r_tp[i]     <= 1'b0;
                r_tp_col[i] <= '0;
            end
        end else begin
            r_tp[0]     <= test_mode;
            r_tp_col[0] <= bar_colour(r_bar_idx);
            for (int i = 1; i <= MEM_LAT; i++) begin
                r_tp[i]     <= r_tp[i-1];
                r_tp_col[i] <= r_tp_col[i-1];
            end
        end
    end

    assign w_rd     = w_visible & ~test_mode;
    assign w_tp_sel = r_tp[MEM_LAT];
    assign w_tp_rgb = r_tp_col[MEM_LAT];
`else
    logic w_unused_test_mode;

    assign w_unused_test_mode = test_mode;
    assign w_rd     = w_visible;
    assign w_tp_sel = 1'b0;
    assign w_tp_rgb = 12'h000;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
            mem_en   <= 1'b0;
        end else begin
            mem_en <= w_rd;
            if (w_rd) begin
                mem_addr <= r_line_base + r_col;
            end
        end
    end

    ctl_t w_ctl;
    ctl_t r_ctl [0:MEM_LAT];
    ctl_t w_out;

    assign w_ctl = {w_visible, w_hsync, w_vsync, w_frame_first};
    assign w_out = r_ctl[MEM_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= MEM_LAT; i++) begin
                r_ctl[i] <= '0;
            end
        end else begin
            r_ctl[0] <= w_ctl;
            for (int i = 1; i <= MEM_LAT; i++) begin
                r_ctl[i] <= r_ctl[i-1];
            end
        end
    end

    logic [11:0] w_pix;

    assign w_pix = w_tp_sel ? w_tp_rgb : fmt_pixel(mem_data, c_fmt);

    always_ff @(posedge clk) begin
        if (rst) begin
            hs          <= ~c_sync_on;
            vs          <= ~c_sync_on;
            de          <= 1'b0;
            rgb         <= 12'h000;
            frame_start <= 1'b0;
        end else begin
            hs          <= w_out.hsync ? c_sync_on : ~c_sync_on;
            vs          <= w_out.vsync ? c_sync_on : ~c_sync_on;
            de          <= w_out.vis;
            rgb         <= w_out.vis ? w_pix : 12'h000;
            frame_start <= w_out.first;
        end
    end

endmodule
`default_nettype wire
